// File: rtl/boruss_prog_mem_if.sv
// Fetch/load bus bundle for boruss_prog_mem.
// The slave modport faces the memory; the master modport faces the core/loader.
interface boruss_prog_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_perr;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              perr_inject;
  logic              busy;
  logic [ADDR_W:0]   load_count;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_data, fetch_valid, fetch_perr,
    input  load_start, load_valid, load_data,
    input  load_last, perr_inject,
    output load_ready, busy, load_count
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_data, fetch_valid, fetch_perr,
    output load_start, load_valid, load_data,
    output load_last, perr_inject,
    input  load_ready, busy, load_count
  );
endinterface

// File: rtl/boruss_prog_mem.sv
// Program memory: self-initialising RAM, 1-cycle fetch port, streaming loader.
// Optional per-word even parity when BORUSS_PMEM_PARITY_EN is defined.
module boruss_prog_mem #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
  input  logic             clk,
  input  logic             reset,
  boruss_prog_mem_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_init_addr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_fetch_valid;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_fetch_go;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_accept   = (r_state == LOAD) && bus.load_valid;
  assign w_fetch_go = (r_state == IDLE) && bus.fetch_req;

  // One shared write port: INIT sweep or accepted load beat
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    unique case (1'b1)
      (r_state == INIT): begin
        w_we    = 1'b1;
        w_waddr = r_init_addr;
        w_wdata = (r_init_addr == '1) ? HALT_WORD : '0;
      end
      w_accept: begin
        w_we    = 1'b1;
        w_waddr = r_ptr;
        w_wdata = bus.load_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we && !reset) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= INIT;
      r_init_addr <= '0;
      r_ptr       <= '0;
      r_count     <= '0;
    end else begin
      unique case (r_state)
        INIT: begin
          r_init_addr <= r_init_addr + ADDR_W'(1);
          if (r_init_addr == '1) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (bus.load_start) begin
            r_state <= LOAD;
            r_ptr   <= '0;
            r_count <= '0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_ptr   <= r_ptr + ADDR_W'(1);
            r_count <= r_count + (ADDR_W + 1)'(1);
            // Last slot ends the load; the pointer never wraps
            if (bus.load_last || r_ptr == '1) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
    end else begin
      r_fetch_valid <= w_fetch_go;
      if (w_fetch_go) begin
        r_fetch_data <= r_mem[bus.fetch_addr];
      end
    end
  end

`ifdef BORUSS_PMEM_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             r_fetch_perr;
  logic             w_wpar;

  // INIT words carry a zero parity bit regardless of content
  assign w_wpar = (r_state == INIT) ? 1'b0
                : (^bus.load_data) ^ bus.perr_inject;

  always_ff @(posedge clk) begin
    if (w_we && !reset) begin
      r_par[w_waddr] <= w_wpar;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_perr <= 1'b0;
    end else begin
      r_fetch_perr <= w_fetch_go &&
        ((^r_mem[bus.fetch_addr]) != r_par[bus.fetch_addr]);
    end
  end

  assign bus.fetch_perr = r_fetch_perr;
`else
  logic w_unused_perr;
  assign w_unused_perr  = bus.perr_inject;
  assign bus.fetch_perr = 1'b0;
`endif

  assign bus.fetch_data  = r_fetch_data;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.load_ready  = (r_state == LOAD);
  assign bus.busy        = (r_state != IDLE);
  assign bus.load_count  = r_count;

endmodule

// File: tb/tb_boruss_prog_mem.sv
// Directed self-checking bench for boruss_prog_mem (8-bit data, 256 words).
// Parity expectations follow BORUSS_PMEM_PARITY_EN.
module tb_boruss_prog_mem;

  localparam int DW = 8;
  localparam int AW = 8;

`ifdef BORUSS_PMEM_PARITY_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  boruss_prog_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  boruss_prog_mem #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int a, input int exp, input logic perr);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'(a);
    step();
    bus.fetch_req  = 1'b0;
    chk($sformatf("fv@%0h", a), int'(bus.fetch_valid), 1);
    chk($sformatf("fd@%0h", a), int'(bus.fetch_data), exp);
    chk($sformatf("fp@%0h", a), int'(bus.fetch_perr), int'(perr));
  endtask

  task automatic beat(input int d, input logic last, input logic inj);
    bus.load_valid  = 1'b1;
    bus.load_data   = 8'(d);
    bus.load_last   = last;
    bus.perr_inject = inj;
    step();
    bus.load_valid  = 1'b0;
    bus.load_last   = 1'b0;
    bus.perr_inject = 1'b0;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    int seen_v;
    n      = 0;
    seen_v = 0;
    bus.fetch_req = 1'b1;
    while (bus.busy && n < 1000) begin
      n++;
      if (bus.fetch_valid) seen_v = 1;
      step();
    end
    bus.fetch_req = 1'b0;
    chk({tag, "_cycles"}, n, 256);
    chk({tag, "_fv"}, seen_v, 0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.fetch_req   = 1'b0;
    bus.fetch_addr  = '0;
    bus.load_start  = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.load_last   = 1'b0;
    bus.perr_inject = 1'b0;
    step();
    reset = 1'b0;

    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_fv", int'(bus.fetch_valid), 0);
    chk("rst_fd", int'(bus.fetch_data), 0);
    chk("rst_fp", int'(bus.fetch_perr), 0);
    chk("rst_rdy", int'(bus.load_ready), 0);
    chk("rst_cnt", int'(bus.load_count), 0);

    wait_init("init");
    fetch(8'hFF, 8'hFF, 1'b0);
    step();
    chk("hold_fv", int'(bus.fetch_valid), 0);
    chk("hold_fd", int'(bus.fetch_data), 8'hFF);
    fetch(8'h10, 8'h00, 1'b0);

    // short load ended by load_last
    start_load();
    chk("ld_busy", int'(bus.busy), 1);
    chk("ld_rdy", int'(bus.load_ready), 1);
    chk("ld_cnt0", int'(bus.load_count), 0);
    beat(8'h11, 1'b0, 1'b0);
    beat(8'h22, 1'b0, 1'b0);
    beat(8'h33, 1'b1, 1'b0);
    chk("ld_cnt3", int'(bus.load_count), 3);
    chk("ld_idle", int'(bus.busy), 0);
    chk("ld_rdy0", int'(bus.load_ready), 0);

    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'h00;
    step();
    bus.fetch_addr = 8'h01;
    chk("b2b0_v", int'(bus.fetch_valid), 1);
    chk("b2b0_d", int'(bus.fetch_data), 8'h11);
    step();
    bus.fetch_addr = 8'h02;
    chk("b2b1_v", int'(bus.fetch_valid), 1);
    chk("b2b1_d", int'(bus.fetch_data), 8'h22);
    step();
    bus.fetch_req = 1'b0;
    chk("b2b2_v", int'(bus.fetch_valid), 1);
    chk("b2b2_d", int'(bus.fetch_data), 8'h33);

    // fetch during LOAD is ignored
    start_load();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'h01;
    step();
    bus.fetch_req  = 1'b0;
    chk("ldf_fv", int'(bus.fetch_valid), 0);
    chk("ldf_fd", int'(bus.fetch_data), 8'h33);
    beat(8'h44, 1'b1, 1'b0);

    // fetch coinciding with load_start returns pre-load data
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'h00;
    bus.load_start = 1'b1;
    step();
    bus.fetch_req  = 1'b0;
    bus.load_start = 1'b0;
    chk("co_fv", int'(bus.fetch_valid), 1);
    chk("co_fd", int'(bus.fetch_data), 8'h44);
    chk("co_busy", int'(bus.busy), 1);
    beat(8'h55, 1'b1, 1'b0);
    chk("co_cnt", int'(bus.load_count), 1);
    fetch(8'h00, 8'h55, 1'b0);
    fetch(8'h01, 8'h22, 1'b0);

    // full-depth load auto-terminates
    start_load();
    for (int i = 0; i < 256; i++) begin
      beat((i * 3 + 7) & 8'hFF, 1'b0, 1'b0);
      if (i == 254) chk("full_busy", int'(bus.busy), 1);
    end
    chk("full_cnt", int'(bus.load_count), 256);
    chk("full_idle", int'(bus.busy), 0);
    fetch(8'hFF, 8'h04, 1'b0);
    fetch(8'h80, 8'h87, 1'b0);
    fetch(8'h00, 8'h07, 1'b0);

    // reset mid-load restarts INIT
    start_load();
    beat(8'h66, 1'b0, 1'b0);
    beat(8'h77, 1'b0, 1'b0);
    chk("mid_cnt", int'(bus.load_count), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_cnt", int'(bus.load_count), 0);
    chk("mid_rst_rdy", int'(bus.load_ready), 0);
    wait_init("reinit");
    fetch(8'h00, 8'h00, 1'b0);
    fetch(8'h01, 8'h00, 1'b0);
    fetch(8'hFF, 8'hFF, 1'b0);

    // parity injection
    start_load();
    beat(8'h5A, 1'b0, 1'b1);
    beat(8'h3C, 1'b1, 1'b0);
    fetch(8'h00, 8'h5A, PERR_EXP);
    fetch(8'h01, 8'h3C, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
